mii_sf_switch: RTL and testbench

// - N-port store-and-forward packet buffer for the MII-style byte-stream path.
// - Each port: rxd/rx_dv in, a private packet FIFO, txd/tx_en out on the same port index.
// - A packet is released on tx only once it is fully received.
// - Packets that do not fit are dropped whole; back-to-back packets are spaced by IFG idle cycles.

---
 rtl/mii_sf_switch.sv | 155 +++++++++++++++
 tb/tb_mii_sf_switch.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mii_sf_switch.sv
// mii_sf_switch: N-port store-and-forward packet buffer for MII-style byte streams.
// Ports:
//   clk         clock, all logic on posedge
//   rst_n       synchronous active-low reset
//   rxd_i       rx data, port i = [i*DW +: DW]
//   rx_dv_i     rx valid per port, high for the whole packet
//   txd_o       tx data, same packing as rxd_i, 0 whenever tx_en_o is low
//   tx_en_o     tx enable per port
//   drop_o      1-cycle pulse per port when a packet is discarded
//   pkt_cnt_o   packets forwarded per port, 16 bits each, saturating   (PKT_STATS_EN only)
//   drop_cnt_o  packets dropped per port, 16 bits each, saturating     (PKT_STATS_EN only)
// Optional feature macro: PKT_STATS_EN adds the per-port statistics counters.
module mii_sf_switch #(
  parameter int N_PORTS = 2,
  parameter int DW      = 8,
  parameter int DEPTH   = 16,
  parameter int IFG     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_PORTS*DW-1:0] rxd_i,
  input  logic [N_PORTS-1:0]    rx_dv_i,
  output logic [N_PORTS*DW-1:0] txd_o,
  output logic [N_PORTS-1:0]    tx_en_o,
`ifdef PKT_STATS_EN
  output logic [N_PORTS-1:0]    drop_o,
  output logic [N_PORTS*16-1:0] pkt_cnt_o,
  output logic [N_PORTS*16-1:0] drop_cnt_o
`else
  output logic [N_PORTS-1:0]    drop_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int GW = $clog2(IFG + 1);
  // RX_SKIP swallows a packet already in progress when reset is released
  typedef enum logic [1:0] {RX_IDLE, RX_WR, RX_DROP, RX_SKIP} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_GAP} tx_state_e;
  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    logic [DW-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] eop_q;
    rx_state_e rx_q, rx_d;
    tx_state_e tx_q, tx_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d, start_q, start_d, rd_ptr_q, rd_ptr_d, pkts_q, pkts_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [DW-1:0] txd_q, txd_d;
    logic [AW-1:0] last;
    logic tx_en_q, tx_en_d, drop_q, drop_d, full, we, commit, sent, rx_dv;
    assign rx_dv = rx_dv_i[p];
    assign last = wr_ptr_q[AW-1:0] - AW'(1);
    // full counts committed and uncommitted entries, against the pre-read rd pointer
    assign full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    always_comb begin
      rx_d = rx_q;
      wr_ptr_d = wr_ptr_q;
      start_d = start_q;
      we = 1'b0;
      commit = 1'b0;
      drop_d = 1'b0;
      case (rx_q)
        RX_IDLE: if (rx_dv) begin
          start_d = wr_ptr_q;
          rx_d = full ? RX_DROP : RX_WR;
          we = !full;
        end
        RX_WR: if (!rx_dv) begin
          commit = 1'b1;
          rx_d = RX_IDLE;
        end else if (full) begin
          rx_d = RX_DROP;
          wr_ptr_d = start_q;
        end else we = 1'b1;
        RX_DROP: if (!rx_dv) begin
          drop_d = 1'b1;
          rx_d = RX_IDLE;
        end
        default: rx_d = rx_dv ? RX_SKIP : RX_IDLE;
      endcase
      if (we) wr_ptr_d = wr_ptr_q + 1'b1;
    end
    always_comb begin
      tx_d = tx_q;
      rd_ptr_d = rd_ptr_q;
      gap_d = gap_q;
      tx_en_d = 1'b0;
      txd_d = '0;
      sent = 1'b0;
      case (tx_q)
        TX_IDLE: tx_d = (pkts_q != '0) ? TX_SEND : TX_IDLE;
        TX_SEND: begin
          tx_en_d = 1'b1;
          txd_d = mem_q[rd_ptr_q[AW-1:0]];
          rd_ptr_d = rd_ptr_q + 1'b1;
          sent = eop_q[rd_ptr_q[AW-1:0]];
          tx_d = sent ? TX_GAP : TX_SEND;
          gap_d = '0;
        end
        default: begin
          gap_d = gap_q + 1'b1;
          // last gap cycle hands straight to SEND so the idle gap is exactly IFG
          if (gap_q == GW'(IFG - 1)) tx_d = (pkts_q != '0) ? TX_SEND : TX_IDLE;
        end
      endcase
      pkts_d = pkts_q + (AW+1)'(commit) - (AW+1)'(sent);
    end
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rx_q <= RX_SKIP;
        tx_q <= TX_IDLE;
        wr_ptr_q <= '0;
        start_q <= '0;
        rd_ptr_q <= '0;
        pkts_q <= '0;
        gap_q <= '0;
        txd_q <= '0;
        tx_en_q <= 1'b0;
        drop_q <= 1'b0;
      end else begin
        rx_q <= rx_d;
        tx_q <= tx_d;
        wr_ptr_q <= wr_ptr_d;
        start_q <= start_d;
        rd_ptr_q <= rd_ptr_d;
        pkts_q <= pkts_d;
        gap_q <= gap_d;
        txd_q <= txd_d;
        tx_en_q <= tx_en_d;
        drop_q <= drop_d;
      end
    end
    always_ff @(posedge clk) begin
      if (rst_n && we) begin
        mem_q[wr_ptr_q[AW-1:0]] <= rxd_i[p*DW +: DW];
        eop_q[wr_ptr_q[AW-1:0]] <= 1'b0;
      end
      if (rst_n && commit) eop_q[last] <= 1'b1;
    end
    assign txd_o[p*DW +: DW] = txd_q;
    assign tx_en_o[p] = tx_en_q;
    assign drop_o[p] = drop_q;
`ifdef PKT_STATS_EN
    logic [15:0] pkt_cnt_q, drop_cnt_q;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        pkt_cnt_q <= '0;
        drop_cnt_q <= '0;
      end else begin
        if (sent && pkt_cnt_q != 16'hFFFF) pkt_cnt_q <= pkt_cnt_q + 16'd1;
        if (drop_d && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
    assign pkt_cnt_o[p*16 +: 16] = pkt_cnt_q;
    assign drop_cnt_o[p*16 +: 16] = drop_cnt_q;
`endif
  end
endmodule

// File: tb/tb_mii_sf_switch.sv
// tb_mii_sf_switch: directed bench with a packet-schedule model checked every cycle.
module tb_mii_sf_switch;
  localparam int NP = 2, DW = 8, DEPTH = 16, IFG = 2, MAXC = 1024;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [NP*DW-1:0] rxd = '0;
  logic [NP-1:0] rx_dv = '0;
  logic [NP*DW-1:0] txd;
  logic [NP-1:0] tx_en, drop;
`ifdef PKT_STATS_EN
  logic [NP*16-1:0] pkt_cnt, drop_cnt;
`endif
  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit exp_en [NP][MAXC];
  bit [7:0] exp_d [NP][MAXC];
  bit exp_drop [NP][MAXC];
  bit [7:0] cur [NP][$];
  bit skip [NP];
  int next_free [NP];
  int tot_pkt [NP];
  int tot_drop [NP];
  mii_sf_switch #(.N_PORTS(NP), .DW(DW), .DEPTH(DEPTH), .IFG(IFG)) dut (
    .clk(clk), .rst_n(rst_n), .rxd_i(rxd), .rx_dv_i(rx_dv),
    .txd_o(txd), .tx_en_o(tx_en), .drop_o(drop)
`ifdef PKT_STATS_EN
    , .pkt_cnt_o(pkt_cnt), .drop_cnt_o(drop_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  // Model: a finished packet either drops (longer than DEPTH) or is scheduled to start at
  // max(end edge + 2, previous start + previous length + IFG), bytes contiguous.
  always @(posedge clk) begin
    cyc++;
    for (int p = 0; p < NP; p++) begin
      if (!rst_n) begin
        skip[p] = 1'b1;
        cur[p].delete();
        next_free[p] = 0;
        tot_pkt[p] = 0;
        tot_drop[p] = 0;
        for (int c = cyc; c < MAXC; c++) begin
          exp_en[p][c] = 1'b0;
          exp_d[p][c] = 8'h00;
          exp_drop[p][c] = 1'b0;
        end
      end else if (skip[p]) begin
        if (!rx_dv[p]) skip[p] = 1'b0;
      end else if (rx_dv[p]) begin
        cur[p].push_back(rxd[p*DW +: DW]);
      end else if (cur[p].size() > 0) begin
        if (cur[p].size() > DEPTH) begin
          exp_drop[p][cyc] = 1'b1;
          tot_drop[p]++;
        end else begin
          int s;
          s = (cyc + 2 > next_free[p]) ? cyc + 2 : next_free[p];
          for (int k = 0; k < cur[p].size(); k++) begin
            exp_en[p][s+k] = 1'b1;
            exp_d[p][s+k] = cur[p][k];
          end
          next_free[p] = s + cur[p].size() + IFG;
          tot_pkt[p]++;
        end
        cur[p].delete();
      end
    end
  end
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC)
      for (int p = 0; p < NP; p++) begin
        chk($sformatf("tx_en%0d@%0d", p, cyc), 16'(tx_en[p]), 16'(exp_en[p][cyc]));
        chk($sformatf("txd%0d@%0d", p, cyc), 16'(txd[p*DW +: DW]), 16'(exp_d[p][cyc]));
        chk($sformatf("drop%0d@%0d", p, cyc), 16'(drop[p]), 16'(exp_drop[p][cyc]));
      end
  end
  task automatic send(input int p, input int len, input logic [7:0] base);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      rx_dv[p] = 1'b1;
      rxd[p*DW +: DW] = base + 8'(i);
    end
    @(negedge clk);
    rx_dv[p] = 1'b0;
    rxd[p*DW +: DW] = 8'h00;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    idle(3);
    chk("rst_tx_en", 16'(tx_en), 16'h0);
    chk("rst_txd", 16'(txd), 16'h0);
    chk("rst_drop", 16'(drop), 16'h0);
`ifdef PKT_STATS_EN
    chk("rst_pkt_cnt", pkt_cnt[15:0], 16'h0);
    chk("rst_drop_cnt", drop_cnt[15:0], 16'h0);
`endif
    rst_n = 1'b1;
    idle(2);
    send(0, 5, 8'h01);
    idle(1);
    chk("sp_lat_e0", 16'(tx_en[0]), 16'h0);
    idle(1);
    chk("sp_lat_e1", 16'(tx_en[0]), 16'h0);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("sp_en", 16'(tx_en[0]), 16'h1);
      chk("sp_byte", 16'(txd[7:0]), 16'(8'h01 + 8'(i)));
      chk("sp_p1_idle", 16'(tx_en[1]), 16'h0);
    end
    idle(1);
    chk("sp_end", 16'(tx_en[0]), 16'h0);
    idle(12);
    send(1, 3, 8'h10);
    send(1, 3, 8'h20);
    idle(15);
    send(0, 17, 8'h30);
    idle(1);
    chk("ovf_drop", 16'(drop[0]), 16'h1);
    idle(1);
    chk("ovf_drop_end", 16'(drop[0]), 16'h0);
    send(0, 4, 8'h50);
    idle(12);
    send(0, 16, 8'h60);
    idle(1);
    chk("bnd_nodrop", 16'(drop[0]), 16'h0);
    idle(20);
    for (int r = 0; r < 3; r++) begin
      send(0, 7, 8'hD0 + 8'(r * 16));
      idle(12);
    end
    send(0, 6, 8'h70);
    fork
      send(0, 6, 8'h80);
      send(1, 4, 8'h90);
    join
    idle(1);
    send(0, 3, 8'hB8);
    idle(30);
`ifdef PKT_STATS_EN
    chk("pkt_cnt0", pkt_cnt[15:0], 16'(tot_pkt[0]));
    chk("drop_cnt0", drop_cnt[15:0], 16'(tot_drop[0]));
    chk("pkt_cnt1", pkt_cnt[31:16], 16'(tot_pkt[1]));
`endif
    send(0, 8, 8'hA0);
    idle(4);
    rst_n = 1'b0;
    rx_dv[0] = 1'b1;
    rxd[7:0] = 8'hEE;
    idle(2);
    chk("mrst_tx_en", 16'(tx_en), 16'h0);
    chk("mrst_txd", 16'(txd), 16'h0);
`ifdef PKT_STATS_EN
    chk("mrst_pkt_cnt", pkt_cnt[15:0], 16'h0);
    chk("mrst_drop_cnt", drop_cnt[15:0], 16'h0);
`endif
    rst_n = 1'b1;
    rxd[7:0] = 8'hEF;
    idle(3);
    rx_dv[0] = 1'b0;
    rxd[7:0] = 8'h00;
    idle(1);
    chk("mrst_nodrop", 16'(drop[0]), 16'h0);
    idle(4);
    chk("mrst_notx", 16'(tx_en[0]), 16'h0);
    send(0, 3, 8'hC0);
    idle(12);
`ifdef PKT_STATS_EN
    chk("end_pkt_cnt0", pkt_cnt[15:0], 16'h1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
